dfs_cfg_sequencer: RTL

- Consumer of the DFS configuration ROM (36-bit words, 1-cycle read latency, no output register).
- On a frequency-change request it reads the ROM entry list for the requested operating point and replays it as MMCM DRP writes.
- Holds the MMCM in reset during the writes, then waits for lock.
- Sits between the DVFS controller and the tile MMCM.

---
 rtl/dfs_cfg_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dfs_cfg_sequencer.sv
// Replays the DFS configuration ROM entry list for one operating point as MMCM DRP writes,
// holding the MMCM in reset during the writes and then waiting for lock.
module dfs_cfg_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int IDX_WIDTH    = 6,
  parameter int STEP_BITS    = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IDX_WIDTH-1:0]  req_idx,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [35:0]           rom_data,
  output logic                  drp_den,
  output logic                  drp_dwe,
  output logic [6:0]            drp_daddr,
  output logic [15:0]           drp_di,
  input  logic                  drp_drdy,
  output logic                  mmcm_rst,
  input  logic                  mmcm_locked,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]     DRDY_LOAD = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STEP_BITS-1:0] STEP_ONE  = STEP_BITS'(1);
  localparam logic [STEP_BITS-1:0] STEP_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROM_RD,
    S_ROM_WAIT,
    S_DRP_WR,
    S_DRP_WAIT,
    S_NEXT,
    S_LOCK_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [STEP_BITS-1:0]  step_q, step_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [6:0]            daddr_q, daddr_d;
  logic [15:0]           di_q, di_d;
  logic                  rst_q, rst_d;
  logic                  err_q, err_d;
  logic                  first_q, first_d;

  // Bits of the ROM word that carry no meaning for the DRP replay.
  logic rom_unused_bits;
  assign rom_unused_bits = ^rom_data[34:23];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      daddr_q <= '0;
      di_q    <= '0;
      rst_q   <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      daddr_q <= daddr_d;
      di_q    <= di_d;
      rst_q   <= rst_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    daddr_d = daddr_q;
    di_d    = di_q;
    rst_d   = rst_q;
    err_d   = err_q;
    first_d = first_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          idx_d   = req_idx;
          step_d  = '0;
          err_d   = 1'b0;
          rst_d   = 1'b1;
          state_d = S_ROM_RD;
        end
      end
      S_ROM_RD: state_d = S_ROM_WAIT;
      S_ROM_WAIT: begin
        last_d  = rom_data[35];
        daddr_d = rom_data[22:16];
        di_d    = rom_data[15:0];
        state_d = S_DRP_WR;
      end
      S_DRP_WR: begin
        cnt_d   = DRDY_LOAD;
        state_d = S_DRP_WAIT;
      end
      S_DRP_WAIT: begin
        if (drp_drdy) begin
          if (last_q) begin
            rst_d   = 1'b0;
            cnt_d   = LOCK_LOAD;
            first_d = 1'b1;
            state_d = S_LOCK_WAIT;
          end else begin
            state_d = S_NEXT;
          end
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          rst_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      // Running off the end of an index's slot is an error rather than a wrap into the next index.
      S_NEXT: begin
        if (step_q == STEP_LAST) begin
          err_d   = 1'b1;
          rst_d   = 1'b0;
          cnt_d   = LOCK_LOAD;
          first_d = 1'b1;
          state_d = S_LOCK_WAIT;
        end else begin
          step_d  = step_q + STEP_ONE;
          state_d = S_ROM_RD;
        end
      end
      // The first cycle after reset release is skipped so a stale lock is never taken.
      S_LOCK_WAIT: begin
        if (first_q) begin
          first_d = 1'b0;
          cnt_d   = cnt_q - CNT_ONE;
        end else if (mmcm_locked) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rom_en    = (state_q == S_ROM_RD);
  assign rom_addr  = {idx_q, step_q};
  assign drp_den   = (state_q == S_DRP_WR);
  assign drp_dwe   = (state_q == S_DRP_WR);
  assign drp_daddr = daddr_q;
  assign drp_di    = di_q;
  assign mmcm_rst  = rst_q;
  assign error     = err_q;

endmodule
